// File: rtl/tb_llr_simd_unit.sv
// Two-stage valid/ready SIMD LLR unit: lane-wise max, extrinsic scaling,
// saturating add and frame-wide running max (ACCMAX). Stage 1 registers the
// accepted beat; stage 2 holds the computed result and the accumulator.
module tb_llr_simd_unit #(
  parameter int unsigned LLR_W = 8,
  parameter int unsigned LANES = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [1:0]             op_i,
  input  logic [1:0]             scale_sel_i,
  input  logic                   last_i,
  input  logic [LANES*LLR_W-1:0] operand_a_i,
  input  logic [LANES*LLR_W-1:0] operand_b_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [LANES*LLR_W-1:0] result_o,
  output logic                   sat_o,
  output logic                   acc_busy_o
);

  localparam int unsigned DW = LANES * LLR_W;

  localparam logic [1:0] OpMax    = 2'd0;
  localparam logic [1:0] OpScale  = 2'd1;
  localparam logic [1:0] OpAddsat = 2'd2;
  localparam logic [1:0] OpAccmax = 2'd3;

  localparam logic signed [LLR_W-1:0] MaxV = {1'b0, {(LLR_W-1){1'b1}}};
  localparam logic signed [LLR_W-1:0] MinV = {1'b1, {(LLR_W-1){1'b0}}};

  typedef enum logic [0:0] {AccIdle, AccRun} acc_state_e;

  acc_state_e    acc_state_q;
  logic [DW-1:0] acc_q;

  logic          s1_valid_q;
  logic [1:0]    s1_op_q;
  logic [1:0]    s1_sel_q;
  logic          s1_last_q;
  logic [DW-1:0] s1_a_q;
  logic [DW-1:0] s1_b_q;

  logic          s1_advance;
  logic          accept;
  logic          emits;
  logic [DW-1:0] lane_res;
  logic [DW-1:0] acc_upd;
  logic [LANES-1:0] lane_sat;

  // Stage 2 always either empty or retiring whenever stage 1 moves forward.
  assign s1_advance = s1_valid_q & (~out_valid_o | out_ready_i);
  assign in_ready_o = ~s1_valid_q | s1_advance;
  assign accept     = in_valid_i & in_ready_o;
  // Non-last ACCMAX beats only update the accumulator and produce no result.
  assign emits      = (s1_op_q != OpAccmax) | s1_last_q;
  assign acc_busy_o = (acc_state_q == AccRun);

  // Per-lane arithmetic on the stage-1 beat.
  always_comb begin
    logic signed [LLR_W-1:0] a, b, c, mx_ab, acc_l, scl, add_r;
    logic [LLR_W-1:0]        m, ms;
    logic signed [LLR_W:0]   sum;
    logic                    abs_sat, add_sat;
    lane_res = '0;
    lane_sat = '0;
    acc_upd  = '0;
    for (int k = 0; k < LANES; k++) begin
      a       = s1_a_q[k*LLR_W +: LLR_W];
      b       = s1_b_q[k*LLR_W +: LLR_W];
      c       = acc_q[k*LLR_W +: LLR_W];
      mx_ab   = (a > b) ? a : b;
      // Frame's first beat seeds the accumulator instead of merging with stale data.
      acc_l   = (acc_busy_o && (c > a)) ? c : a;
      abs_sat = 1'b0;
      if (a == MinV) begin
        m       = MaxV;
        abs_sat = 1'b1;
      end else begin
        m = a[LLR_W-1] ? -a : a;
      end
      unique case (s1_sel_q)
        2'd0:    ms = m;
        2'd1:    ms = m >> 1;
        2'd2:    ms = m - (m >> 2);
        default: ms = m - (m >> 3);
      endcase
      scl     = a[LLR_W-1] ? -$signed(ms) : $signed(ms);
      sum     = {a[LLR_W-1], a} + {b[LLR_W-1], b};
      add_sat = (sum[LLR_W] != sum[LLR_W-1]);
      if (add_sat) add_r = sum[LLR_W] ? MinV : MaxV;
      else         add_r = sum[LLR_W-1:0];
      unique case (s1_op_q)
        OpMax:    lane_res[k*LLR_W +: LLR_W] = mx_ab;
        OpScale:  begin
          lane_res[k*LLR_W +: LLR_W] = scl;
          lane_sat[k]                = abs_sat;
        end
        OpAddsat: begin
          lane_res[k*LLR_W +: LLR_W] = add_r;
          lane_sat[k]                = add_sat;
        end
        default:  lane_res[k*LLR_W +: LLR_W] = acc_l;
      endcase
      acc_upd[k*LLR_W +: LLR_W] = acc_l;
    end
  end

  // Stage 1: capture the accepted beat with its sideband controls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= 2'd0;
      s1_sel_q   <= 2'd0;
      s1_last_q  <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_op_q    <= op_i;
      s1_sel_q   <= scale_sel_i;
      s1_last_q  <= last_i;
      s1_a_q     <= operand_a_i;
      s1_b_q     <= operand_b_i;
    end else if (s1_advance) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Stage 2: output register, held stable while the consumer stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      result_o    <= '0;
      sat_o       <= 1'b0;
    end else if (s1_advance) begin
      out_valid_o <= emits;
      if (emits) begin
        result_o <= lane_res;
        sat_o    <= |lane_sat;
      end
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  // Accumulator FSM: open on a non-last ACCMAX beat, close on the last one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_state_q <= AccIdle;
      acc_q       <= '0;
    end else if (s1_advance && (s1_op_q == OpAccmax)) begin
      if (s1_last_q) begin
        acc_state_q <= AccIdle;
      end else begin
        acc_state_q <= AccRun;
        acc_q       <= acc_upd;
      end
    end
  end

endmodule

// File: tb/tb_tb_llr_simd_unit.sv
// Self-checking bench for tb_llr_simd_unit: integer reference model feeding an
// expected-result queue, plus scenario tasks with explicit lane checks.
module tb_tb_llr_simd_unit;

  localparam int LLR_W = 8;
  localparam int LANES = 8;
  localparam int DW    = LANES * LLR_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [1:0]    sel;
  logic          last;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic          sat;
  logic          acc_busy;

  int checks = 0;
  int errors = 0;

  logic [DW:0]   exp_q[$];
  logic [DW:0]   got_q[$];
  logic [DW:0]   mon_e;
  logic [DW-1:0] m_acc;
  logic          m_busy;

  always #5 clk = ~clk;

  tb_llr_simd_unit #(.LLR_W(LLR_W), .LANES(LANES)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .scale_sel_i(sel), .last_i(last), .operand_a_i(a), .operand_b_i(b),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result), .sat_o(sat),
    .acc_busy_o(acc_busy)
  );

  // Scoreboard: a retire happens at the next rising edge; inputs are stable here.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected actual=%h/%b required=none", result, sat);
      end else begin
        mon_e = exp_q.pop_front();
        if ({sat, result} !== mon_e) begin
          errors++;
          $display("FAIL scoreboard actual=%h/%b required=%h/%b", result, sat,
                   mon_e[DW-1:0], mon_e[DW]);
        end
      end
      got_q.push_back({sat, result});
    end
  end

  function automatic logic [DW-1:0] pk4(input int l0, input int l1, input int l2, input int l3);
    logic [DW-1:0] r;
    r        = '0;
    r[7:0]   = l0[7:0];
    r[15:8]  = l1[7:0];
    r[23:16] = l2[7:0];
    r[31:24] = l3[7:0];
    return r;
  endfunction

  // Integer reference model; returns {sat, result}.
  function automatic logic [DW:0] model(input logic [1:0] o, input logic [1:0] s,
                                        input logic [DW-1:0] va, input logic [DW-1:0] vb,
                                        input logic [DW-1:0] acc, input logic busy);
    logic [DW-1:0] r;
    logic          st;
    int            x, y, z, m;
    r  = '0;
    st = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      x = $signed(va[k*LLR_W +: LLR_W]);
      y = $signed(vb[k*LLR_W +: LLR_W]);
      z = $signed(acc[k*LLR_W +: LLR_W]);
      case (o)
        2'd0: m = (x > y) ? x : y;
        2'd1: begin
          m = (x < 0) ? -x : x;
          if (m > 127) begin m = 127; st = 1'b1; end
          case (s)
            2'd0: m = m;
            2'd1: m = m / 2;
            2'd2: m = m - m / 4;
            default: m = m - m / 8;
          endcase
          if (x < 0) m = -m;
        end
        2'd2: begin
          m = x + y;
          if (m > 127) begin m = 127; st = 1'b1; end
          else if (m < -128) begin m = -128; st = 1'b1; end
        end
        default: m = (busy && z > x) ? z : x;
      endcase
      r[k*LLR_W +: LLR_W] = m[LLR_W-1:0];
    end
    return {st, r};
  endfunction

  // Offer one beat until accepted (bounded), then update the model.
  task automatic send(input logic [1:0] o, input logic [1:0] s, input logic l,
                      input logic [DW-1:0] va, input logic [DW-1:0] vb);
    logic        took;
    int          n;
    logic [DW:0] e;
    op = o; sel = s; last = l; a = va; b = vb; in_valid = 1'b1;
    took = 1'b0;
    n    = 0;
    while (!took && n < 50) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!took) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted");
    end else begin
      e = model(o, s, va, vb, m_acc, m_busy);
      if (o == 2'd3) begin
        if (l) begin
          exp_q.push_back(e);
          m_busy = 1'b0;
        end else begin
          m_acc  = e[DW-1:0];
          m_busy = 1'b1;
        end
      end else begin
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_outputs(input int n);
    int c;
    c = 0;
    while (got_q.size() < n && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (got_q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL output_timeout actual=%0d required=%0d", got_q.size(), n);
    end
  endtask

  task automatic take(output logic [DW:0] v);
    if (got_q.size() > 0) v = got_q.pop_front();
    else v = 'x;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid actual=%b required=0", out_valid); end
    if (result !== '0) begin errors++; $display("FAIL reset_result actual=%h required=0", result); end
    if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat actual=%b required=0", sat); end
    if (acc_busy !== 1'b0) begin errors++; $display("FAIL reset_acc_busy actual=%b required=0", acc_busy); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready actual=%b required=1", in_ready); end
  endtask

  task automatic test_max;
    got_q.delete();
    out_ready = 1'b1;
    send(2'd0, 2'd0, 1'b0, pk4(-123, -1, 0, 0), pk4(16, -2, 0, 0));
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL max_latency_early actual=%b required=0", out_valid); end
    @(posedge clk);
    #1;
    checks += 4;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL max_latency actual=%b required=1", out_valid); end
    if (result[7:0] !== 8'h10) begin errors++; $display("FAIL max_lane0 actual=%h required=10", result[7:0]); end
    if (result[15:8] !== 8'hFF) begin errors++; $display("FAIL max_lane1 actual=%h required=ff", result[15:8]); end
    if (sat !== 1'b0) begin errors++; $display("FAIL max_sat actual=%b required=0", sat); end
    wait_outputs(1);
  endtask

  task automatic test_scale;
    logic [DW:0] t;
    got_q.delete();
    send(2'd1, 2'd2, 1'b0, pk4(100, -100, -128, 3), '0);
    send(2'd1, 2'd3, 1'b0, pk4(64, 0, 0, 0), '0);
    send(2'd1, 2'd1, 1'b0, pk4(-7, 0, 0, 0), '0);
    send(2'd1, 2'd0, 1'b0, pk4(-128, 0, 0, 0), '0);
    wait_outputs(4);
    checks += 4;
    take(t);
    if (t !== {1'b1, pk4(75, -75, -96, 3)}) begin errors++; $display("FAIL scale_sel2 actual=%h required=%h", t, {1'b1, pk4(75, -75, -96, 3)}); end
    take(t);
    if (t !== {1'b0, pk4(56, 0, 0, 0)}) begin errors++; $display("FAIL scale_sel3 actual=%h required=%h", t, {1'b0, pk4(56, 0, 0, 0)}); end
    take(t);
    if (t !== {1'b0, pk4(-3, 0, 0, 0)}) begin errors++; $display("FAIL scale_sel1 actual=%h required=%h", t, {1'b0, pk4(-3, 0, 0, 0)}); end
    take(t);
    if (t !== {1'b1, pk4(-127, 0, 0, 0)}) begin errors++; $display("FAIL scale_sel0 actual=%h required=%h", t, {1'b1, pk4(-127, 0, 0, 0)}); end
  endtask

  task automatic test_addsat;
    logic [DW:0] t;
    got_q.delete();
    send(2'd2, 2'd0, 1'b0, pk4(100, 0, 0, 0), pk4(100, 0, 0, 0));
    send(2'd2, 2'd0, 1'b0, pk4(-100, 0, 0, 0), pk4(-100, 0, 0, 0));
    send(2'd2, 2'd0, 1'b0, pk4(20, 0, 0, 0), pk4(-5, 0, 0, 0));
    wait_outputs(3);
    checks += 3;
    take(t);
    if (t !== {1'b1, pk4(127, 0, 0, 0)}) begin errors++; $display("FAIL addsat_pos actual=%h required=%h", t, {1'b1, pk4(127, 0, 0, 0)}); end
    take(t);
    if (t !== {1'b1, pk4(-128, 0, 0, 0)}) begin errors++; $display("FAIL addsat_neg actual=%h required=%h", t, {1'b1, pk4(-128, 0, 0, 0)}); end
    take(t);
    if (t !== {1'b0, pk4(15, 0, 0, 0)}) begin errors++; $display("FAIL addsat_mid actual=%h required=%h", t, {1'b0, pk4(15, 0, 0, 0)}); end
  endtask

  task automatic test_accmax;
    logic [DW:0] t;
    got_q.delete();
    checks++;
    if (acc_busy !== 1'b0) begin errors++; $display("FAIL acc_idle actual=%b required=0", acc_busy); end
    send(2'd3, 2'd0, 1'b0, pk4(5, 0, 0, 0), '0);
    @(posedge clk);
    #1;
    checks++;
    if (acc_busy !== 1'b1) begin errors++; $display("FAIL acc_busy_open actual=%b required=1", acc_busy); end
    send(2'd0, 2'd0, 1'b0, pk4(1, 0, 0, 0), pk4(2, 0, 0, 0));
    send(2'd3, 2'd0, 1'b0, pk4(-7, 0, 0, 0), '0);
    checks++;
    if (acc_busy !== 1'b1) begin errors++; $display("FAIL acc_busy_interleave actual=%b required=1", acc_busy); end
    send(2'd3, 2'd0, 1'b1, pk4(20, 0, 0, 0), '0);
    @(posedge clk);
    #1;
    checks++;
    if (acc_busy !== 1'b0) begin errors++; $display("FAIL acc_busy_close actual=%b required=0", acc_busy); end
    wait_outputs(2);
    repeat (5) @(posedge clk);
    #1;
    checks += 3;
    if (got_q.size() != 2) begin errors++; $display("FAIL acc_output_count actual=%0d required=2", got_q.size()); end
    take(t);
    if (t !== {1'b0, pk4(2, 0, 0, 0)}) begin errors++; $display("FAIL acc_interleaved_max actual=%h required=%h", t, {1'b0, pk4(2, 0, 0, 0)}); end
    take(t);
    if (t !== {1'b0, pk4(20, 0, 0, 0)}) begin errors++; $display("FAIL acc_frame_result actual=%h required=%h", t, {1'b0, pk4(20, 0, 0, 0)}); end
  endtask

  task automatic test_back_to_back;
    logic [DW:0] t;
    logic        took;
    int          idx;
    got_q.delete();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      if (idx < 4) begin
        op = 2'd2; sel = 2'd0; last = 1'b0;
        a = pk4(idx + 1, 0, 0, 0); b = pk4(10, 0, 0, 0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      if (took && idx < 4) begin
        exp_q.push_back(model(2'd2, 2'd0, a, b, m_acc, m_busy));
        idx++;
      end
    end
    in_valid = 1'b0;
    checks += 3;
    if (idx != 2) begin errors++; $display("FAIL bp_accepted actual=%0d required=2", idx); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready actual=%b required=0", in_ready); end
    if (got_q.size() != 0) begin errors++; $display("FAIL bp_stalled_output actual=%0d required=0", got_q.size()); end
    out_ready = 1'b1;
    for (int i = idx; i < 4; i++) send(2'd2, 2'd0, 1'b0, pk4(i + 1, 0, 0, 0), pk4(10, 0, 0, 0));
    wait_outputs(4);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != 4) begin errors++; $display("FAIL bp_output_count actual=%0d required=4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      take(t);
      checks++;
      if (t !== {1'b0, pk4(11 + i, 0, 0, 0)}) begin
        errors++;
        $display("FAIL bp_order_%0d actual=%h required=%h", i, t, {1'b0, pk4(11 + i, 0, 0, 0)});
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [DW:0] t;
    got_q.delete();
    out_ready = 1'b1;
    send(2'd3, 2'd0, 1'b0, pk4(9, 0, 0, 0), '0);
    send(2'd3, 2'd0, 1'b0, pk4(4, 0, 0, 0), '0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    m_busy = 1'b0;
    exp_q.delete();
    checks += 2;
    if (acc_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_acc_busy actual=%b required=0", acc_busy); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid actual=%b required=0", out_valid); end
    send(2'd3, 2'd0, 1'b1, pk4(-3, 0, 0, 0), '0);
    wait_outputs(1);
    take(t);
    checks++;
    if (t !== {1'b0, pk4(-3, 0, 0, 0)}) begin errors++; $display("FAIL rst_mid_new_frame actual=%h required=%h", t, {1'b0, pk4(-3, 0, 0, 0)}); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = 2'd0; sel = 2'd0; last = 1'b0; a = '0; b = '0;
    m_acc = '0; m_busy = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_max();
    test_scale();
    test_addsat();
    test_accmax();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
